// File: rtl/alu_md_unit.sv
// alu_md_unit: execute-stage ALU with an iterative multiply/divide engine.
// Single-cycle ALU ops are combinational. mult/div run for WIDTH+1 cycles
// and write HI/LO. Stall tells the hazard unit to hold HI/LO instructions
// while the engine is busy.
// Optional build macro: ALU_MD_OVERFLOW_EN adds signed add/sub overflow
// detection. Without it, Overflow is tied to 0.
module alu_md_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic             Flush,
  input  logic [1:0]       AluOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] AluResult,
  output logic             Zero,
  output logic             Busy,
  output logic             Stall,
  output logic             Overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic [WIDTH-1:0] acc_reg;   // product high half / partial remainder
  logic [WIDTH-1:0] q_reg;     // multiplier bits / dividend -> quotient
  logic [WIDTH-1:0] m_reg;     // multiplicand / divisor magnitude
  logic [CW-1:0]    cnt_reg;
  logic             is_div_reg, neg_q_reg, neg_r_reg;

  // Instruction decode
  logic is_rtype, is_md, is_hilo, is_mthi, is_mtlo, accept;
  assign is_rtype = (AluOp == 2'b10);
  assign is_md    = is_rtype && (Funct[5:2] == 4'b0110);
  assign is_mthi  = is_rtype && (Funct == 6'b010001);
  assign is_mtlo  = is_rtype && (Funct == 6'b010011);
  assign is_hilo  = is_md || (is_rtype && (Funct[5:2] == 4'b0100));
  // A stalled or flushed instruction is never accepted
  assign accept   = (state_reg == IDLE) && En && !Flush && is_md;

  assign Busy  = (state_reg != IDLE);
  assign Stall = Busy && En && is_hilo;

  // Operand magnitudes for signed ops (even Funct = signed variant)
  logic             signed_op, sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  assign signed_op = !Funct[0];
  assign sa    = signed_op && SrcA[WIDTH-1];
  assign sb    = signed_op && SrcB[WIDTH-1];
  assign mag_a = sa ? -SrcA : SrcA;
  assign mag_b = sb ? -SrcB : SrcB;

  // One iteration of shift-add multiply and restoring divide
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  assign mul_sum   = {1'b0, acc_reg} + (q_reg[0] ? {1'b0, m_reg} : '0);
  assign div_shift = {acc_reg, q_reg[WIDTH-1]};
  assign div_ge    = (div_shift >= {1'b0, m_reg});
  assign div_diff  = div_shift[WIDTH-1:0] - m_reg;

  // Sign correction; a zero divisor leaves the all-ones quotient as is
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  assign prod_fix = neg_q_reg ? -{acc_reg, q_reg} : {acc_reg, q_reg};
  assign quot_fix = (neg_q_reg && (m_reg != '0)) ? -q_reg : q_reg;
  assign rem_fix  = neg_r_reg ? -acc_reg : acc_reg;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state: WIDTH RUN steps then one FIX cycle; Flush aborts
  always_comb begin
    state_next = state_reg;
    if (Flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (accept) state_next = RUN;
        RUN:     if (cnt_reg == CW'(WIDTH - 1)) state_next = FIX;
        FIX:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Engine datapath and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_reg     <= '0;
      lo_reg     <= '0;
      acc_reg    <= '0;
      q_reg      <= '0;
      m_reg      <= '0;
      cnt_reg    <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
    end else if (accept) begin
      is_div_reg <= Funct[1];
      neg_q_reg  <= sa ^ sb;
      neg_r_reg  <= sa;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      if (Funct[1]) begin
        q_reg <= mag_a;
        m_reg <= mag_b;
      end else begin
        q_reg <= mag_b;
        m_reg <= mag_a;
      end
    end else if (state_reg == RUN && !Flush) begin
      cnt_reg <= cnt_reg + CW'(1);
      if (is_div_reg) begin
        acc_reg <= div_ge ? div_diff : div_shift[WIDTH-1:0];
        q_reg   <= {q_reg[WIDTH-2:0], div_ge};
      end else begin
        acc_reg <= mul_sum[WIDTH:1];
        q_reg   <= {mul_sum[0], q_reg[WIDTH-1:1]};
      end
    end else if (state_reg == FIX && !Flush) begin
      if (is_div_reg) begin
        hi_reg <= rem_fix;
        lo_reg <= quot_fix;
      end else begin
        {hi_reg, lo_reg} <= prod_fix;
      end
    end else if (state_reg == IDLE && En && !Flush) begin
      if (is_mthi) hi_reg <= SrcA;
      if (is_mtlo) lo_reg <= SrcA;
    end
  end

  // Single-cycle ALU
  logic [WIDTH-1:0] sum, diff;
  logic             slt, sltu;
  assign sum  = SrcA + SrcB;
  assign diff = SrcA - SrcB;
  assign slt  = ($signed(SrcA) < $signed(SrcB));
  assign sltu = (SrcA < SrcB);

  // Result mux
  always_comb begin
    AluResult = '0;
    case (AluOp)
      2'b00: AluResult = sum;
      2'b01: AluResult = diff;
      2'b11: AluResult = {{(WIDTH-1){1'b0}}, slt};
      default: begin
        case (Funct)
          6'b100000, 6'b100001: AluResult = sum;
          6'b100010, 6'b100011: AluResult = diff;
          6'b100100: AluResult = SrcA & SrcB;
          6'b100101: AluResult = SrcA | SrcB;
          6'b100110: AluResult = SrcA ^ SrcB;
          6'b100111: AluResult = ~(SrcA | SrcB);
          6'b101010: AluResult = {{(WIDTH-1){1'b0}}, slt};
          6'b101011: AluResult = {{(WIDTH-1){1'b0}}, sltu};
          6'b010000: AluResult = hi_reg;
          6'b010010: AluResult = lo_reg;
          default:   AluResult = '0;
        endcase
      end
    endcase
  end

  assign Zero = (AluResult == '0);

`ifdef ALU_MD_OVERFLOW_EN
  logic add_sel, sub_sel, add_ov, sub_ov;
  assign add_sel  = (AluOp == 2'b00) || (is_rtype && Funct == 6'b100000);
  assign sub_sel  = (AluOp == 2'b01) || (is_rtype && Funct == 6'b100010);
  assign add_ov   = (SrcA[WIDTH-1] == SrcB[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
  assign sub_ov   = (SrcA[WIDTH-1] != SrcB[WIDTH-1]) && (diff[WIDTH-1] != SrcA[WIDTH-1]);
  assign Overflow = (add_sel && add_ov) || (sub_sel && sub_ov);
`else
  assign Overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu_md_unit.sv
// Directed testbench for alu_md_unit (WIDTH=32).
module tb_alu_md_unit;

  logic        clk, reset, En, Flush;
  logic [1:0]  AluOp;
  logic [5:0]  Funct;
  logic [31:0] SrcA, SrcB, AluResult;
  logic        Zero, Busy, Stall, Overflow;

  int total = 0;
  int bad   = 0;
  int cyc;
  int stalls;

  localparam logic [5:0] F_MULT = 6'b011000, F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV  = 6'b011010, F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI = 6'b010000, F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTHI = 6'b010001;

  alu_md_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .En(En), .Flush(Flush),
    .AluOp(AluOp), .Funct(Funct), .SrcA(SrcA), .SrcB(SrcB),
    .AluResult(AluResult), .Zero(Zero), .Busy(Busy), .Stall(Stall),
    .Overflow(Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b);
    En = en; AluOp = op; Funct = f; SrcA = a; SrcB = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mult/div and wait (bounded) for Busy to fall; returns busy cycles
  task automatic run_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    drive(1'b1, 2'b10, f, a, b);
    tick();
    En = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    $display("md funct=%b a=%h b=%h busy_cycles=%0d", f, a, b, n);
  endtask

  task automatic read_hilo(input logic [5:0] f, output logic [31:0] v);
    drive(1'b1, 2'b10, f, 32'h0, 32'h0);
    #1;
    v = AluResult;
  endtask

  logic [31:0] v;

  initial begin
    reset = 1'b1; Flush = 1'b0;
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0);
    #12 reset = 1'b0;
    #1;
    // Reset state
    chk("rst_busy", 32'(Busy), 32'd0);
    read_hilo(F_MFHI, v); chk("rst_hi", v, 32'h0);
    read_hilo(F_MFLO, v); chk("rst_lo", v, 32'h0);

    // Single-cycle ALU ops
    drive(1'b1, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1); #1;
    chk("slt", AluResult, 32'h1);
    drive(1'b1, 2'b10, 6'b101011, 32'hFFFFFFFF, 32'h1); #1;
    chk("sltu", AluResult, 32'h0);
    chk("sltu_zero", 32'(Zero), 32'd1);
    drive(1'b1, 2'b00, 6'b0, 32'd5, 32'd7); #1;
    chk("add", AluResult, 32'd12);
    drive(1'b1, 2'b01, 6'b0, 32'd5, 32'd7); #1;
    chk("sub", AluResult, 32'hFFFFFFFE);
    drive(1'b1, 2'b11, 6'b0, 32'h80000000, 32'h0); #1;
    chk("aluop_slt", AluResult, 32'h1);
    drive(1'b1, 2'b10, 6'b100100, 32'hF0F0_1234, 32'h0FF0_FF00); #1;
    chk("and", AluResult, 32'h00F0_1200);
    drive(1'b1, 2'b10, 6'b100101, 32'hF0F0_1234, 32'h0FF0_FF00); #1;
    chk("or", AluResult, 32'hFFF0_FF34);
    drive(1'b1, 2'b10, 6'b100110, 32'hF0F0_1234, 32'h0FF0_FF00); #1;
    chk("xor", AluResult, 32'hFF00_ED34);
    drive(1'b1, 2'b10, 6'b100111, 32'hF0F0_1234, 32'h0FF0_FF00); #1;
    chk("nor", AluResult, 32'h000F_00CB);
    drive(1'b1, 2'b10, 6'b111111, 32'h5, 32'h7); #1;
    chk("bad_funct", AluResult, 32'h0);
    drive(1'b0, 2'b10, F_MULT, 32'h5, 32'h7); #1;
    chk("mult_result_zero", AluResult, 32'h0);

    // Overflow
    drive(1'b1, 2'b00, 6'b0, 32'h7FFFFFFF, 32'h1); #1;
    chk("ovf_add_res", AluResult, 32'h80000000);
`ifdef ALU_MD_OVERFLOW_EN
    chk("ovf_add", 32'(Overflow), 32'd1);
`else
    chk("ovf_add", 32'(Overflow), 32'd0);
`endif
    drive(1'b1, 2'b10, 6'b100001, 32'h7FFFFFFF, 32'h1); #1;
    chk("ovf_addu", 32'(Overflow), 32'd0);
    drive(1'b0, 2'b00, 6'b0, 32'h0, 32'h0);
    tick();

    // Multiply
    run_md(F_MULT, 32'hFFFFFFFF, 32'd3, cyc);
    chk("mult_cycles", 32'(cyc), 32'd33);
    read_hilo(F_MFHI, v); chk("mult_hi", v, 32'hFFFFFFFF);
    read_hilo(F_MFLO, v); chk("mult_lo", v, 32'hFFFFFFFD);
    run_md(F_MULTU, 32'hFFFFFFFF, 32'd3, cyc);
    read_hilo(F_MFHI, v); chk("multu_hi", v, 32'h00000002);
    read_hilo(F_MFLO, v); chk("multu_lo", v, 32'hFFFFFFFD);

    // Divide
    run_md(F_DIVU, 32'd100, 32'd7, cyc);
    chk("divu_cycles", 32'(cyc), 32'd33);
    read_hilo(F_MFLO, v); chk("divu_lo", v, 32'd14);
    read_hilo(F_MFHI, v); chk("divu_hi", v, 32'd2);
    run_md(F_DIV, 32'hFFFFFFF9, 32'd2, cyc);
    read_hilo(F_MFLO, v); chk("div_neg_lo", v, 32'hFFFFFFFD);
    read_hilo(F_MFHI, v); chk("div_neg_hi", v, 32'hFFFFFFFF);
    run_md(F_DIV, 32'd5, 32'd0, cyc);
    read_hilo(F_MFHI, v); chk("div0_hi", v, 32'd5);
    read_hilo(F_MFLO, v); chk("div0_lo", v, 32'hFFFFFFFF);
    run_md(F_DIV, 32'h80000000, 32'hFFFFFFFF, cyc);
    read_hilo(F_MFLO, v); chk("divmin_lo", v, 32'h80000000);
    read_hilo(F_MFHI, v); chk("divmin_hi", v, 32'h0);

    // Stall while busy
    drive(1'b1, 2'b10, F_MULT, 32'd6, 32'd7);
    tick();
    drive(1'b1, 2'b00, 6'b0, 32'd1, 32'd1); #1;
    chk("stall_alu", 32'(Stall), 32'd0);
    drive(1'b1, 2'b10, F_MFLO, 32'h0, 32'h0); #1;
    stalls = 0; cyc = 0;
    while (Busy === 1'b1 && cyc < 100) begin
      if (Stall === 1'b1) stalls++;
      cyc++;
      tick();
    end
    $display("stall run busy_cycles=%0d stall_cycles=%0d", cyc, stalls);
    chk("stall_cycles", 32'(stalls), 32'd33);
    chk("stall_drop", 32'(Stall), 32'd0);
    chk("stall_mflo", AluResult, 32'd42);

    // Async reset mid-operation
    drive(1'b1, 2'b10, F_MULT, 32'hFFFFFFFF, 32'd3);
    tick();
    En = 1'b0;
    repeat (9) tick();
    reset = 1'b1;
    read_hilo(F_MFHI, v);
    chk("rst_mid_busy", 32'(Busy), 32'd0);
    chk("rst_mid_hi", v, 32'h0);
    read_hilo(F_MFLO, v); chk("rst_mid_lo", v, 32'h0);
    En = 1'b0;
    #1 reset = 1'b0;
    tick();

    // mthi, then flush a mult mid-run
    drive(1'b1, 2'b10, F_MTHI, 32'h1234, 32'h0);
    tick();
    read_hilo(F_MFHI, v); chk("mthi", v, 32'h1234);
    drive(1'b1, 2'b10, F_MULT, 32'd5, 32'd5);
    tick();
    En = 1'b0;
    repeat (9) tick();
    Flush = 1'b1;
    tick();
    Flush = 1'b0;
    chk("flush_busy", 32'(Busy), 32'd0);
    read_hilo(F_MFHI, v); chk("flush_hi", v, 32'h1234);
    read_hilo(F_MFLO, v); chk("flush_lo", v, 32'h0);

    // Flush beats a same-cycle issue
    drive(1'b1, 2'b10, F_MULT, 32'd5, 32'd5);
    Flush = 1'b1;
    tick();
    Flush = 1'b0; En = 1'b0;
    #1;
    chk("flush_issue", 32'(Busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_md_unit.md
Name: alu_md_unit

Overview:
- Parametrised execute-stage ALU for the pipelined MIPS core; successor to the combinational ALU control decode.
- Decodes AluOp/Funct internally and computes single-cycle ALU results.
- Adds an iterative multiply/divide engine with HI/LO registers and a stall handshake to the hazard unit.
- Sits in EX, fed by ID/EX pipeline registers; AluResult goes to EX/MEM.

Parameters:
WIDTH, 32, operand/result width in bits (even, >= 8)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high reset
En  input  1  valid instruction in EX this cycle
Flush  input  1  synchronous abort of in-flight mult/div
AluOp  input  2  00 add, 01 sub, 10 use Funct, 11 slt
Funct  input  6  R-type function field
SrcA  input  WIDTH  operand A (rs)
SrcB  input  WIDTH  operand B (rt / immediate)
AluResult  output  WIDTH  combinational result
Zero  output  1  AluResult == 0
Busy  output  1  mult/div engine active (registered)
Stall  output  1  combinational stall request to hazard unit
Overflow  output  1  signed overflow (see Optional Feature)

Behaviour:
- Single-cycle ops, combinational. Funct codes: 100000/100001 add/addu; 100010/100011 sub/subu; 100100 and; 100101 or; 100110 xor; 100111 nor; 101010 slt (signed); 101011 sltu. Any other Funct with AluOp=10 -> AluResult 0.
- slt/sltu results are zero-extended 1-bit. Add/sub wrap modulo 2^WIDTH.
- HI/LO ops (AluOp=10): 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010010 mflo, 010001 mthi, 010011 mtlo.
- mfhi/mflo: AluResult = HI/LO. For mult/div/mthi/mtlo, AluResult = 0.
- FSM states: IDLE, RUN, FIX.
- IDLE: En and mult/div -> latch operand magnitudes (signed ops), signs and op type; go RUN; Busy=1 from next cycle.
- RUN: one shift-add (mult) or restoring-subtract (div) step per cycle. After exactly WIDTH steps, go FIX.
- FIX: apply sign correction and write HI/LO; go IDLE; Busy=0 next cycle. Busy is high for WIDTH+1 cycles; the result is readable on the cycle Busy falls.
- Mult: {HI,LO} = full 2*WIDTH product.
- Div: LO = quotient (truncated toward zero), HI = remainder with the sign of the dividend.
- Div by zero: HI = dividend, LO = all ones. Normal latency; no exception.
- Most-negative / -1 (signed): LO = most-negative, HI = 0.
- Stall = Busy and En and Funct in {mult, multu, div, divu, mfhi, mflo, mthi, mtlo} with AluOp=10. Non-HI/LO instructions never stall.
- A stalled op is not accepted. The pipeline holds it and it issues the cycle after Busy falls.
- mthi/mtlo in IDLE: HI/LO written at the clock edge. mfhi/mflo in the next cycle sees the new value.
- Flush in any state: FSM -> IDLE next edge, Busy=0, HI/LO unchanged.
- Flush has priority over a same-cycle issue: the op is not accepted.
- Reset, asynchronous, also mid-operation: state IDLE, Busy=0, HI=0, LO=0, internal accumulators 0.
- Combinational outputs follow their inputs during reset.

Optional Feature:
- Macro: ALU_MD_OVERFLOW_EN.
- Defined: Overflow=1 when signed add (AluOp=00 or Funct 100000) or signed sub (AluOp=01 or Funct 100010) overflows two's complement; 0 otherwise, including addu/subu. AluResult is unaffected.
- Undefined: Overflow tied to 0 and no overflow logic is synthesised.

Test Plan:
- ALU ops (WIDTH=32): AluOp=10, Funct=101010, SrcA=0xFFFFFFFF, SrcB=1 -> AluResult=1. Same with Funct=101011 -> 0, Zero=1. AluOp=00, 5+7 -> 12.
- mult: SrcA=0xFFFFFFFF, SrcB=3 -> Busy high 33 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFD. multu with the same operands -> HI=0x00000002, LO=0xFFFFFFFD.
- Division: divu 100/7 -> LO=14, HI=2. div 0xFFFFFFF9 (-7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 5/0 -> HI=5, LO=0xFFFFFFFF. div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Stall: issue mult, then hold En with mflo -> Stall=1 every cycle until Busy falls, then Stall=0 and AluResult=LO.
- Reset/flush mid-op: reset asserted in cycle 10 of a mult -> Busy=0, HI=LO=0 immediately. Flush in cycle 10 after mthi 0x1234 -> Busy=0 next cycle, HI=0x1234 retained.
- ALU_MD_OVERFLOW_EN defined: add 0x7FFFFFFF+1 -> Overflow=1, AluResult=0x80000000. addu of the same operands -> Overflow=0.
